lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_ctrl_if.sv | 18 +
 rtl/lcd_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lcd_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_if.sv
// LCD request channel between the LSU-side register shim and lcd_ctrl.
// Carries one {rs,data} byte per valid/ready handshake.
interface lcd_ctrl_if;
  logic       valid;
  logic       ready;
  logic       rs;
  logic [7:0] data;

  modport master (
    output valid, rs, data,
    input  ready
  );

  modport slave (
    input  valid, rs, data,
    output ready
  );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-style parallel LCD write controller.
// Queues bytes in a 4-deep FIFO and replays them with setup/EN/hold/wait timing.
module lcd_ctrl #(
  parameter int SETUP_CYC      = 2,
  parameter int EN_HIGH_CYC    = 25,
  parameter int HOLD_CYC       = 2,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  lcd_ctrl_if.slave  req,
  input  logic       i_lcd_on,
  input  logic       i_lcd_blon,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on,
  output logic       o_lcd_blon,
  output logic       o_busy
);

  localparam logic [19:0] SETUP_L = 20'(SETUP_CYC - 1);
  localparam logic [19:0] EN_L    = 20'(EN_HIGH_CYC - 1);
  localparam logic [19:0] HOLD_L  = 20'(HOLD_CYC - 1);
  localparam logic [19:0] CMD_L   = 20'(CMD_WAIT_CYC - 1);
  localparam logic [19:0] CLR_L   = 20'(CLEAR_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EN_HI,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t      state, state_nxt;
  logic [19:0] cnt, cnt_nxt;
  logic [8:0]  mem [4];
  logic [1:0]  wptr, rptr;
  logic [2:0]  count;
  logic [8:0]  xfer;
  logic        full, empty;
  logic        push, pop;
  logic        is_clear;
  logic [19:0] wait_l;

  assign full      = (count == 3'd4);
  assign empty     = (count == 3'd0);
  assign req.ready = !i_reset && !full;
  assign push      = req.valid && req.ready;
  assign o_lcd_rw  = 1'b0;
  assign o_busy    = (state != S_IDLE) || !empty;

  // Clear (0x01) and return-home (0x02/0x03) need the long settle time
  assign is_clear = !xfer[8] && (xfer[7:2] == 6'd0)
                    && (xfer[1:0] != 2'd0);
  assign wait_l   = is_clear ? CLR_L : CMD_L;

  // FIFO storage; flushing is done through the pointers
  always_ff @(posedge i_clk) begin
    if (push) mem[wptr] <= {req.rs, req.data};
  end

  // FIFO pointers, occupancy and the transfer register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      xfer  <= '0;
    end else begin
      if (push) wptr <= wptr + 2'd1;
      if (pop) begin
        rptr <= rptr + 2'd1;
        xfer <= mem[rptr];
      end
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  // FSM state and phase counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: each timed phase ends when cnt reaches its limit
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_SETUP;
          cnt_nxt   = '0;
        end
      end
      S_SETUP: begin
        if (cnt == SETUP_L) begin
          state_nxt = S_EN_HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end
      S_EN_HI: begin
        if (cnt == EN_L) begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end
      S_HOLD: begin
        if (cnt == HOLD_L) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end
      S_WAIT: begin
        if (cnt == wait_l) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 20'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Registered pins: bus driven SETUP..HOLD, EN only in EN_HI
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_lcd_data <= '0;
      o_lcd_rs   <= 1'b0;
      o_lcd_en   <= 1'b0;
      o_lcd_on   <= 1'b0;
      o_lcd_blon <= 1'b0;
    end else begin
      o_lcd_en   <= (state == S_EN_HI);
      o_lcd_on   <= i_lcd_on;
      o_lcd_blon <= i_lcd_blon;
      if (state inside {S_SETUP, S_EN_HI, S_HOLD}) begin
        o_lcd_rs   <= xfer[8];
        o_lcd_data <= xfer[7:0];
      end
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: vector table, corner sequences and
// randomized traffic against a timeline model of the transfer protocol.
module tb_lcd_ctrl;

  localparam int S   = 2;
  localparam int E   = 25;
  localparam int H   = 2;
  localparam int CW  = 40;
  localparam int CLW = 150;

  logic       i_clk;
  logic       i_reset;
  logic       i_lcd_on, i_lcd_blon;
  logic [7:0] o_lcd_data;
  logic       o_lcd_rs, o_lcd_rw, o_lcd_en;
  logic       o_lcd_on, o_lcd_blon, o_busy;

  lcd_ctrl_if rif();

  lcd_ctrl #(
    .SETUP_CYC      (S),
    .EN_HIGH_CYC    (E),
    .HOLD_CYC       (H),
    .CMD_WAIT_CYC   (CW),
    .CLEAR_WAIT_CYC (CLW)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .req        (rif),
    .i_lcd_on   (i_lcd_on),
    .i_lcd_blon (i_lcd_blon),
    .o_lcd_data (o_lcd_data),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_on   (o_lcd_on),
    .o_lcd_blon (o_lcd_blon),
    .o_busy     (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct packed {
    logic       rs;
    logic [7:0] d;
  } item_t;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         exp_wait;
    bit         tog;
  } vec_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    ek    = 0;
  logic  on_v  = 1'b0;
  logic  blon_v = 1'b0;
  bit    last_acc;
  logic  en_q  = 1'b0;
  item_t seen[$];

  // Reference model: timeline of transfers derived from the phase lengths
  item_t mq[$];
  item_t cur, last_out;
  bit    have_cur   = 0;
  int    t_pop      = 0;
  int    free_edge  = 0;
  logic  exp_on     = 1'b0;
  logic  exp_blon   = 1'b0;

  function automatic int wait_of(item_t it);
    if (!it.rs && (it.d inside {8'h01, 8'h02, 8'h03})) return CLW;
    return CW;
  endfunction

  function automatic void model_edge(int k, logic v, logic rs,
                                     logic [7:0] d, logic on,
                                     logic blon, logic rst);
    int    sz;
    item_t it;
    if (rst) begin
      mq.delete();
      have_cur  = 0;
      last_out  = '0;
      free_edge = k + 1;
      exp_on    = 1'b0;
      exp_blon  = 1'b0;
      return;
    end
    sz = mq.size();
    if (k >= free_edge && sz > 0) begin
      if (have_cur) last_out = cur;
      cur       = mq.pop_front();
      have_cur  = 1;
      t_pop     = k;
      free_edge = k + S + E + H + wait_of(cur) + 1;
    end
    if (v && sz < 4) begin
      it.rs = rs;
      it.d  = d;
      mq.push_back(it);
    end
    exp_on   = on;
    exp_blon = blon;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               name, act, exp, ek);
    end
  endtask

  task automatic cycle(input logic v, input logic rs,
                       input logic [7:0] d, input logic rst);
    logic  en_e, busy_e;
    item_t out_e;
    item_t it;
    rif.valid  = v;
    rif.rs     = rs;
    rif.data   = d;
    i_reset    = rst;
    i_lcd_on   = on_v;
    i_lcd_blon = blon_v;
    #1;
    chk("ready", 32'(rif.ready), 32'(!rst && mq.size() < 4));
    last_acc = v && rif.ready;
    @(posedge i_clk);
    ek++;
    model_edge(ek, v, rs, d, on_v, blon_v, rst);
    #1;
    en_e = have_cur && ek >= t_pop + S + 1 && ek <= t_pop + S + E;
    out_e = (have_cur && ek >= t_pop + 1) ? cur : last_out;
    busy_e = (have_cur && ek <= free_edge - 2) || mq.size() > 0;
    chk("en", 32'(o_lcd_en), 32'(en_e));
    chk("rs", 32'(o_lcd_rs), 32'(out_e.rs));
    chk("data", 32'(o_lcd_data), 32'(out_e.d));
    chk("busy", 32'(o_busy), 32'(busy_e));
    chk("rw", 32'(o_lcd_rw), 32'd0);
    chk("on", 32'(o_lcd_on), 32'(exp_on));
    chk("blon", 32'(o_lcd_blon), 32'(exp_blon));
    if (o_lcd_en && !en_q) begin
      it.rs = o_lcd_rs;
      it.d  = o_lcd_data;
      seen.push_back(it);
    end
    en_q = o_lcd_en;
  endtask

  // One transfer from idle; measures EN position/width and busy fall
  task automatic send_one(input vec_t t);
    int    k0, rel, first, width, fall;
    item_t it;
    first = -1;
    width = 0;
    fall  = -1;
    seen.delete();
    cycle(1'b1, t.rs, t.d, 1'b0);
    chk("accept", 32'(last_acc), 32'd1);
    k0 = ek;
    for (int n = 0; n < 1000; n++) begin
      if (t.tog) begin
        on_v   = 1'($urandom_range(0, 1));
        blon_v = 1'($urandom_range(0, 1));
      end
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      rel = ek - k0;
      if (o_lcd_en && first < 0) first = rel;
      if (o_lcd_en) width++;
      if (!o_busy) begin
        fall = rel;
        break;
      end
    end
    it.rs = t.rs;
    it.d  = t.d;
    chk("en_first", 32'(first), 32'(2 + S));
    chk("en_width", 32'(width), 32'(E));
    chk("busy_fall", 32'(fall), 32'(S + E + H + t.exp_wait + 1));
    chk("pulses", 32'(seen.size()), 32'd1);
    if (seen.size() == 1) chk("xfer_item", 32'(seen[0]), 32'(it));
  endtask

  task automatic drain(input int bound);
    for (int n = 0; n < bound && o_busy; n++)
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
    chk("drained", 32'(o_busy), 32'd0);
  endtask

  vec_t  vt[10];
  item_t sent[$];
  int    acc, en_hi, nseen;

  initial begin
    vt[0] = '{1'b1, 8'h41, CW,  1'b0};
    vt[1] = '{1'b0, 8'h01, CLW, 1'b0};
    vt[2] = '{1'b0, 8'h02, CLW, 1'b0};
    vt[3] = '{1'b0, 8'h03, CLW, 1'b0};
    vt[4] = '{1'b0, 8'h38, CW,  1'b0};
    vt[5] = '{1'b1, 8'h01, CW,  1'b0};
    vt[6] = '{1'b0, 8'h00, CW,  1'b0};
    vt[7] = '{1'b0, 8'h04, CW,  1'b0};
    vt[8] = '{1'b0, 8'h80, CW,  1'b0};
    vt[9] = '{1'b0, 8'h01, CLW, 1'b1};

    rif.valid = 1'b0;
    rif.rs    = 1'b0;
    rif.data  = 8'h00;
    i_reset   = 1'b1;
    i_lcd_on  = 1'b0;
    i_lcd_blon = 1'b0;

    on_v   = 1'b1;
    blon_v = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rst_data", 32'(o_lcd_data), 32'h00);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_on", 32'(o_lcd_on), 32'd0);
    on_v   = 1'b0;
    blon_v = 1'b0;
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    chk("ready_after_rst", 32'(rif.ready), 32'd1);

    for (int i = 0; i < 10; i++) send_one(vt[i]);

    // Valid held 8 cycles: five accepts, pulses in FIFO order
    seen.delete();
    sent.delete();
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      item_t it;
      it.rs = 1'(i);
      it.d  = 8'h60 + 8'(i);
      cycle(1'b1, it.rs, it.d, 1'b0);
      if (last_acc) begin
        acc++;
        sent.push_back(it);
      end
    end
    chk("burst_accepts", 32'(acc), 32'd5);
    drain(3000);
    chk("burst_pulses", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen.size() && i < sent.size(); i++)
      chk("burst_order", 32'(seen[i]), 32'(sent[i]));

    // Reset in the 10th EN_HI cycle with three entries queued
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b1, 8'hA0 + 8'(i), 1'b0);
    en_hi = 0;
    for (int n = 0; n < 200 && en_hi < 10; n++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
      if (o_lcd_en) en_hi++;
    end
    chk("mid_en_reached", 32'(en_hi), 32'd10);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("mid_rst_en", 32'(o_lcd_en), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    nseen = seen.size();
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    chk("mid_rst_ready", 32'(rif.ready), 32'd1);
    for (int n = 0; n < 300; n++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    chk("mid_rst_no_pulse", 32'(seen.size()), 32'(nseen));

    // Randomized traffic against the model
    for (int n = 0; n < 5000; n++) begin
      logic       v, rs, rst;
      logic [7:0] d;
      v   = ($urandom_range(0, 24) == 0);
      rs  = 1'($urandom_range(0, 1));
      d   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3))
                                        : 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 7) == 0) on_v = ~on_v;
      if ($urandom_range(0, 7) == 0) blon_v = ~blon_v;
      cycle(v, rs, d, rst);
    end
    drain(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
